// File: rtl/ir_err_compute.sv
// IR line-sensor error front-end: walks the A2D over 8 channels and
// produces a weighted, saturated left-minus-right error for the PID.
module ir_err_compute #(
  parameter int RES_W      = 12,
  parameter int ERR_W      = 10,
  parameter int SETTLE_CYC = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  output logic             strt_cnv,
  output logic [2:0]       chnnl,
  input  logic             cnv_cmplt,
  input  logic [RES_W-1:0] res,
  output logic [ERR_W-1:0] err_sat,
  output logic             err_vld,
  output logic             busy
);

  localparam int ACC_W = RES_W + 5;
  localparam int CNT_W = $clog2(SETTLE_CYC + 1);

  localparam logic signed [ACC_W-1:0] MAX_E =
    ACC_W'((1 <<< (ERR_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MIN_E = -MAX_E - 1;

  typedef enum logic [2:0] {
    IDLE,
    CNV,
    WAIT,
    SETTLE,
    DONE
  } state_t;

  state_t                   state;
  logic signed [ACC_W-1:0]  acc;
  logic        [CNT_W-1:0]  cnt;
  logic        [ACC_W-1:0]  mag;
  logic signed [ACC_W-1:0]  term;
  logic signed [ACC_W-1:0]  scaled;
  logic        [ERR_W-1:0]  sat;

  // Channel weight is 2^(ch/2); odd channels are the right side and subtract.
  always_comb begin
    mag  = ACC_W'(res) << chnnl[2:1];
    term = chnnl[0] ? -$signed(mag) : $signed(mag);
  end

  // Divide by 8 keeping sign, then clamp into the signed output range.
  always_comb begin
    scaled = acc >>> 3;
    if (scaled > MAX_E)
      sat = MAX_E[ERR_W-1:0];
    else if (scaled < MIN_E)
      sat = MIN_E[ERR_W-1:0];
    else
      sat = scaled[ERR_W-1:0];
  end

  // Round sequencer with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      strt_cnv <= 1'b0;
      chnnl    <= 3'd0;
      err_sat  <= '0;
      err_vld  <= 1'b0;
      busy     <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
    end else begin
      err_vld <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            acc      <= '0;
            chnnl    <= 3'd0;
            strt_cnv <= 1'b1;
            busy     <= 1'b1;
            state    <= CNV;
          end
        end
        CNV: begin
          strt_cnv <= 1'b0;
          state    <= WAIT;
        end
        WAIT: begin
          if (cnv_cmplt) begin
            acc <= acc + term;
            cnt <= '0;
            if (chnnl == 3'd7)
              state <= DONE;
            else
              state <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
            chnnl    <= chnnl + 3'd1;
            strt_cnv <= 1'b1;
            state    <= CNV;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          err_sat <= sat;
          err_vld <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_err_compute.sv
// Bench for ir_err_compute: A2D responder, scoreboard of expected
// err_sat values, and a monitor on the conversion handshake.
module tb_ir_err_compute;

  localparam int SETTLE = 8;

  logic        clk_tb = 1'b0;
  logic        rst_n  = 1'b1;
  logic        go     = 1'b0;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt = 1'b0;
  logic [11:0] res       = 12'd0;
  logic [9:0]  err_sat;
  logic        err_vld;
  logic        busy;

  int checks = 0;
  int passes = 0;

  logic [11:0] tbl[8];
  logic [9:0]  sb[$];
  logic [9:0]  last_exp = 10'd0;

  int pulse_cnt = 0;
  int vld_cnt   = 0;
  int exp_ch    = 0;
  int gap       = 0;
  int cmplt_cnt = 0;
  logic prev_strt = 1'b0;

  ir_err_compute #(
    .RES_W(12), .ERR_W(10), .SETTLE_CYC(SETTLE)
  ) dut (
    .clk(clk_tb), .rst_n(rst_n), .go(go),
    .strt_cnv(strt_cnv), .chnnl(chnnl),
    .cnv_cmplt(cnv_cmplt), .res(res),
    .err_sat(err_sat), .err_vld(err_vld),
    .busy(busy)
  );

  always #5 clk_tb = ~clk_tb;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic logic [9:0] model();
    int a = 0;
    int s;
    for (int c = 0; c < 8; c++) begin
      int w = 1 << (c / 2);
      a += ((c % 2) ? -w : w) * int'(tbl[c]);
    end
    s = a >>> 3;
    if (s > 511) s = 511;
    if (s < -512) s = -512;
    return s[9:0];
  endfunction

  // A2D model: answer 3 cycles after each start pulse.
  initial begin
    logic [2:0] ch_l;
    forever begin
      @(negedge clk_tb);
      if (strt_cnv) begin
        ch_l = chnnl;
        repeat (3) @(negedge clk_tb);
        res       = tbl[ch_l];
        cnv_cmplt = 1'b1;
        @(negedge clk_tb);
        cnv_cmplt = 1'b0;
        res       = 12'd0;
        cmplt_cnt++;
      end
    end
  end

  // Monitor: pulse shape, channel order, spacing, result strobe.
  always @(negedge clk_tb) begin
    if (rst_n) begin
      if (strt_cnv) begin
        chk("strt_width", 32'(prev_strt), 0);
        chk("chnnl_order", 32'(chnnl), exp_ch[2:0]);
        if (pulse_cnt > 0)
          chk("settle_gap", 32'(gap >= SETTLE), 1);
        exp_ch++;
        pulse_cnt++;
        gap = 0;
      end else begin
        gap++;
      end
      if (err_vld) begin
        vld_cnt++;
        if (sb.size() > 0)
          chk("err_sat", 32'(err_sat), 32'(sb.pop_front()));
        else
          chk("spurious_vld", 32'(err_vld), 0);
      end
    end
    prev_strt = strt_cnv;
  end

  task automatic start_round(input bit expect_vld);
    exp_ch    = 0;
    pulse_cnt = 0;
    vld_cnt   = 0;
    if (expect_vld) begin
      last_exp = model();
      sb.push_back(last_exp);
    end
    @(negedge clk_tb);
    go = 1'b1;
    @(negedge clk_tb);
    go = 1'b0;
    chk("busy_rise", 32'(busy), 1);
  endtask

  task automatic finish_round();
    int n = 0;
    while (vld_cnt == 0 && n < 2000) begin
      @(negedge clk_tb);
      #1;
      n++;
    end
    chk("vld_seen", 32'(vld_cnt), 1);
    chk("busy_fall", 32'(busy), 0);
    chk("pulse_cnt", 32'(pulse_cnt), 8);
    repeat (30) @(negedge clk_tb);
    chk("vld_once", 32'(vld_cnt), 1);
    chk("pulse_final", 32'(pulse_cnt), 8);
    chk("err_hold", 32'(err_sat), 32'(last_exp));
  endtask

  initial begin
    int n;
    int base;
    for (int i = 0; i < 8; i++) tbl[i] = 12'd0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk_tb);
    chk("rst_strt", 32'(strt_cnv), 0);
    chk("rst_chnnl", 32'(chnnl), 0);
    chk("rst_err", 32'(err_sat), 0);
    chk("rst_vld", 32'(err_vld), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_tb);

    // Centre-left only: +2048/8 = +256.
    tbl[0] = 12'h800;
    start_round(1'b1);
    finish_round();
    chk("ch0_val", 32'(err_sat), 32'h100);

    // Heavy left sensor saturates positive.
    tbl[0] = 12'h000;
    tbl[6] = 12'hFFF;
    start_round(1'b1);
    finish_round();
    chk("sat_pos", 32'(err_sat), 32'h1FF);

    // Heavy right sensor saturates negative.
    tbl[6] = 12'h000;
    tbl[7] = 12'hFFF;
    start_round(1'b1);
    finish_round();
    chk("sat_neg", 32'(err_sat), 32'h200);

    // Reset partway through: after ch3 result, during settle.
    for (int i = 0; i < 8; i++) tbl[i] = 12'h123;
    base = cmplt_cnt;
    start_round(1'b0);
    n = 0;
    while (cmplt_cnt < base + 4 && n < 2000) begin
      @(negedge clk_tb);
      n++;
    end
    chk("reach_ch3", 32'(cmplt_cnt - base), 4);
    @(negedge clk_tb);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_strt", 32'(strt_cnv), 0);
    chk("arst_chnnl", 32'(chnnl), 0);
    chk("arst_err", 32'(err_sat), 0);
    chk("arst_vld", 32'(err_vld), 0);
    chk("arst_busy", 32'(busy), 0);
    repeat (2) @(negedge clk_tb);
    rst_n = 1'b1;
    repeat (40) @(negedge clk_tb);
    chk("no_vld_rst", 32'(vld_cnt), 0);
    chk("err_after_rst", 32'(err_sat), 0);

    // Balanced sensors cancel; a go while busy must be ignored.
    for (int i = 0; i < 8; i++) tbl[i] = 12'h555;
    start_round(1'b1);
    repeat (20) @(negedge clk_tb);
    go = 1'b1;
    @(negedge clk_tb);
    go = 1'b0;
    finish_round();
    chk("balanced", 32'(err_sat), 0);

    // Random round after the reset recovery.
    for (int i = 0; i < 8; i++) tbl[i] = 12'($urandom_range(0, 4095));
    start_round(1'b1);
    finish_round();

    // Mild right bias: (100-300+2*50-2*20)/8 = -140/8 -> -18.
    for (int i = 0; i < 8; i++) tbl[i] = 12'd0;
    tbl[0] = 12'd100;
    tbl[1] = 12'd300;
    tbl[2] = 12'd50;
    tbl[3] = 12'd20;
    start_round(1'b1);
    finish_round();
    chk("neg_small", 32'(err_sat), 32'h3EE);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
